// File: rtl/lm_sm_sequencer_if.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer_if
//
// Bundles the control, memory and register-file signals of the load-multiple /
// store-multiple sequencer. Clock and Reset are kept outside the interface.
//
// Signal summary (direction as seen from the sequencer, i.e. the slave port):
//   Start        in   request to begin a sequence (sampled only in IDLE)
//   Mode         in   0 = LM (memory -> registers), 1 = SM (registers -> memory)
//   Mask         in   register-select mask, bit i selects Ri
//   Base         in   first memory address
//   Mem_Addr     out  current memory address
//   Mem_Read     out  LM read request
//   Mem_Write    out  SM write request
//   Mem_Data_Out out  SM write data
//   Mem_Data_In  in   LM read data, valid while Mem_Ready is high
//   Mem_Ready    in   memory completes the current request this cycle
//   Address_A    out  register-file read address (SM)
//   Data_A       in   register-file read data (combinational from Address_A)
//   Address_C    out  register-file write address (LM)
//   Data_C       out  register-file write data (LM)
//   Write        out  register-file write enable
//   Busy         out  high while a sequence is in progress (XFER, DONE)
//   Done         out  one-cycle completion pulse
//
// Modports:
//   master - control FSM / memory / register-file side
//   slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface lm_sm_sequencer_if #(
  parameter int DATA_W = 16
);

  // Control side
  logic              Start;
  logic              Mode;
  logic [7:0]        Mask;
  logic [DATA_W-1:0] Base;
  logic              Busy;
  logic              Done;

  // Data-memory side
  logic [DATA_W-1:0] Mem_Addr;
  logic              Mem_Read;
  logic              Mem_Write;
  logic [DATA_W-1:0] Mem_Data_Out;
  logic [DATA_W-1:0] Mem_Data_In;
  logic              Mem_Ready;

  // Register-file side
  logic [2:0]        Address_A;
  logic [DATA_W-1:0] Data_A;
  logic [2:0]        Address_C;
  logic [DATA_W-1:0] Data_C;
  logic              Write;

  modport master (
    output Start,
    output Mode,
    output Mask,
    output Base,
    output Mem_Data_In,
    output Mem_Ready,
    output Data_A,
    input  Busy,
    input  Done,
    input  Mem_Addr,
    input  Mem_Read,
    input  Mem_Write,
    input  Mem_Data_Out,
    input  Address_A,
    input  Address_C,
    input  Data_C,
    input  Write
  );

  modport slave (
    input  Start,
    input  Mode,
    input  Mask,
    input  Base,
    input  Mem_Data_In,
    input  Mem_Ready,
    input  Data_A,
    output Busy,
    output Done,
    output Mem_Addr,
    output Mem_Read,
    output Mem_Write,
    output Mem_Data_Out,
    output Address_A,
    output Address_C,
    output Data_C,
    output Write
  );

endinterface

// File: rtl/lm_sm_sequencer.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer
//
// Multi-cycle load-multiple / store-multiple sequencer for the IITB RISC
// datapath. On an accepted Start it latches an 8-bit register mask, a base
// address and the transfer direction, then walks the mask from R0 to R7,
// issuing one memory transfer per selected register at consecutive addresses.
//
//   LM (Mode=0): memory -> register file via Address_C / Data_C / Write.
//   SM (Mode=1): register file -> memory via Address_A / Data_A.
//
// A request is held on the memory bus until Mem_Ready completes it; each
// Mem_Ready=0 cycle simply stalls the sequence.
//
// Ports:
//   Clock  in  rising-edge clock
//   Reset  in  asynchronous, active-high reset; forces IDLE and all outputs 0
//   bus        lm_sm_sequencer_if.slave (control, memory, register-file signals)
//
// All outputs are combinational from the state registers and the memory /
// register-file inputs; there is no output pipeline register.
// -----------------------------------------------------------------------------
module lm_sm_sequencer #(
  parameter int DATA_W = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  lm_sm_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        pend_q,  pend_d;   // registers still to transfer
  logic [DATA_W-1:0] addr_q,  addr_d;   // address of the current transfer
  logic              mode_q,  mode_d;   // latched direction, 1 = SM

  logic [2:0]        cur;               // register served this cycle
  logic [7:0]        cur_onehot;
  logic              last_xfer;         // cur is the only bit left in pend

  // Priority encoder: index of the lowest set bit (R0 has priority).
  // Scanning downwards lets the lowest set bit overwrite any higher one.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  assign cur        = lowest_set(pend_q);
  assign cur_onehot = 8'b0000_0001 << cur;
  assign last_xfer  = ((pend_q & ~cur_onehot) == 8'h00);

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pend_q  <= 8'h00;
      addr_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and outputs
  always_comb begin
    state_d          = state_q;
    pend_d           = pend_q;
    addr_d           = addr_q;
    mode_d           = mode_q;

    bus.Busy         = 1'b0;
    bus.Done         = 1'b0;
    bus.Mem_Addr     = '0;
    bus.Mem_Read     = 1'b0;
    bus.Mem_Write    = 1'b0;
    bus.Mem_Data_Out = '0;
    bus.Address_A    = 3'd0;
    bus.Address_C    = 3'd0;
    bus.Data_C       = '0;
    bus.Write        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          pend_d = bus.Mask;
          addr_d = bus.Base;
          mode_d = bus.Mode;
          // An empty mask completes without touching memory or registers.
          state_d = (bus.Mask != 8'h00) ? XFER : DONE;
        end
      end

      XFER: begin
        bus.Busy     = 1'b1;
        bus.Mem_Addr = addr_q;
        if (mode_q) begin
          bus.Mem_Write    = 1'b1;
          bus.Address_A    = cur;
          bus.Mem_Data_Out = bus.Data_A;
        end else begin
          bus.Mem_Read  = 1'b1;
          bus.Address_C = cur;
          bus.Data_C    = bus.Mem_Data_In;
          // Register write only in the cycle the read data is valid.
          bus.Write     = bus.Mem_Ready;
        end
        if (bus.Mem_Ready) begin
          pend_d = pend_q & ~cur_onehot;
          // Address wraps naturally modulo 2^DATA_W.
          addr_d = addr_q + DATA_W'(1);
          if (last_xfer) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        bus.Busy = 1'b1;
        bus.Done = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-cycle load-multiple / store-multiple sequencer for the IITB RISC datapath. Given an 8-bit register mask and a base memory address, it walks the mask from R0 to R7. For each selected register it issues one memory transfer at consecutive addresses. In LM mode it drives the register-file write port (Address_C/Data_C/Write); in SM mode it drives the register-file read port (Address_A/Data_A). It sits between the control FSM, the register file and the data-memory interface.

## Interface
- DATA_W, 16, data and memory-address width
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  request to begin; sampled only in IDLE
- Mode  in  1  0 = LM (memory to registers), 1 = SM (registers to memory)
- Mask  in  8  register-select mask; bit i selects Ri; latched on accepted Start
- Base  in  DATA_W  first memory address; latched on accepted Start
- Mem_Addr  out  DATA_W  current memory address
- Mem_Read  out  1  LM read request
- Mem_Write  out  1  SM write request
- Mem_Data_Out  out  DATA_W  SM write data (equals Data_A)
- Mem_Data_In  in  DATA_W  LM read data; valid when Mem_Ready=1
- Mem_Ready  in  1  memory completes the current request this cycle
- Address_A  out  3  register-file read address (SM)
- Data_A  in  DATA_W  register-file read data (combinational from Address_A)
- Address_C  out  3  register-file write address (LM)
- Data_C  out  DATA_W  register-file write data (LM)
- Write  out  1  register-file write enable
- Busy  out  1  high in XFER and DONE
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, XFER, DONE. Internal registers: pend[7:0], addr[DATA_W-1:0], mode.
- IDLE: on Start=1 latch pend=Mask, addr=Base, mode=Mode.
  - Mask != 0: go to XFER.
  - Mask == 0: go directly to DONE. No memory or register-file activity.
- XFER: cur = index of the lowest set bit of pend (priority encoder, R0 first). Mem_Addr=addr.
  - LM: Mem_Read=1. Address_C=cur, Data_C=Mem_Data_In. Write = Mem_Ready (combinational, only in the completing cycle).
  - SM: Mem_Write=1. Address_A=cur, Mem_Data_Out=Data_A.
  - On Mem_Ready=1: clear pend[cur] and set addr=addr+1, modulo 2^DATA_W (0xFFFF wraps to 0x0000). If the cleared bit was the last set bit, go to DONE.
  - On Mem_Ready=0: hold all state and outputs; the request stays asserted (stall).
- DONE: Done=1 for exactly one cycle, then IDLE.
- Start is ignored in XFER and DONE. It is not queued.
- Mem_Read, Mem_Write and Write are never high outside XFER. Mem_Read and Mem_Write are mutually exclusive.
- Reset (any time, including mid-transfer): state=IDLE, pend=0, addr=0. All outputs are 0, including Busy, Done, Write, Mem_Read, Mem_Write, the addresses and the data buses. A partially completed LM keeps the registers already written; there are no further writes.

## Timing
- Start accepted at edge k → XFER from cycle k+1.
- With Mem_Ready held high and N set mask bits (N ≥ 1): XFER lasts N cycles, one transfer per cycle. Done is high in cycle k+N+1, and IDLE resumes at k+N+2.
- Each Mem_Ready=0 cycle adds one cycle of latency.
- Mask=0: Done is high in cycle k+1.
- Earliest next Start acceptance is the cycle after Done. Start held high continuously restarts from IDLE.
- Outputs in XFER are combinational from state, pend, addr, Data_A, Mem_Data_In and Mem_Ready. There is no extra pipeline register.

## Test plan
- LM, Mask=0x05, Base=0x0100, Mem_Ready=1, memory returns 0xAAAA then 0x5555 → R0=0xAAAA written at addr 0x0100, R2=0x5555 written at 0x0101. Write is high exactly 2 cycles; Done is high in cycle k+3.
- SM, Mask=0x81, Base=0x0040, R0=0x1234, R7=0xBEEF, Mem_Ready low for 2 cycles on the first request → Mem_Write holds addr 0x0040 with data 0x1234 for 3 cycles, then 0x0041/0xBEEF. Done follows after 4 XFER cycles.
- Mask=0x00 with Start → Done is high the next cycle. Mem_Read, Mem_Write and Write stay 0 throughout.
- LM, Mask=0x03, Base=0xFFFF → transfers at 0xFFFF then 0x0000.
- LM, Mask=0xFF, Reset asserted asynchronously after 3 transfers → all outputs 0 immediately. R0–R2 are written and R3–R7 are untouched. After Reset is released the block is in IDLE with Busy=0.
- Start pulsed again during XFER with a different Mask → ignored. The original sequence completes unchanged, with exactly one Done pulse.
